// File: rtl/sb_cfg_pkg.sv
// Shared switch-block config types: mux-code enum, chain-length helper, mux select helper.
// Chain length grows by one parity bit when SB_CFG_PARITY_EN is defined.
// Pure declarations; no timing or flow control.
package sb_cfg_pkg;

    typedef enum logic [1:0] {
        MUX_TRACK = 2'b00,
        MUX_PIN   = 2'b01,
        MUX_ZERO  = 2'b10
    } mux_code_e;

    function automatic int cfg_chain_len(input int num_pins);
`ifdef SB_CFG_PARITY_EN
        return 4 * num_pins + 1;
`else
        return 4 * num_pins;
`endif
    endfunction

    // Code 2'b11 is unused and deliberately routes the default track.
    function automatic logic mux_sel(input mux_code_e code, input logic track, input logic pin);
        case (code)
            MUX_PIN:  return pin;
            MUX_ZERO: return 1'b0;
            default:  return track;
        endcase
    endfunction

endpackage

// File: rtl/sb_cfg_chain.sv
// Double-buffered config chain: serial staging shifter, bit counter, commit gate, active register.
// Shift and commit take effect on the prog_clk edge; active feeds routing with no added latency.
// No backpressure: shifting beyond a full frame saturates the count and spills bits through ccff_tail.
module sb_cfg_chain
    import sb_cfg_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int CHAIN_LEN = 16
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              ccff_head,
    input  logic              ccff_en,
    input  logic              ccff_commit,
    output logic [DATA_W-1:0] active,
    output logic              ccff_tail,
    output logic              cfg_ready,
    output logic              cfg_err
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CHAIN_LEN);

    logic [CHAIN_LEN-1:0] staging_q, staging_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [DATA_W-1:0]    active_q, active_d;
    logic                 err_q, err_d;
    logic                 full, parity_ok, accept;

    always_comb begin
        full = (count_q == FULL);
`ifdef SB_CFG_PARITY_EN
        parity_ok = ~(^staging_q);
`else
        parity_ok = 1'b1;
`endif
        // Commit is judged on the pre-shift staging/count even when a shift lands this cycle.
        accept    = ccff_commit & full & parity_ok;
        staging_d = staging_q;
        count_d   = count_q;
        active_d  = active_q;
        err_d     = err_q;
        if (ccff_en) begin
            staging_d = {staging_q[CHAIN_LEN-2:0], ccff_head};
            count_d   = full ? count_q : count_q + CNT_W'(1);
        end
        if (accept) begin
            active_d = staging_q[CHAIN_LEN-1 -: DATA_W];
            count_d  = ccff_en ? CNT_W'(1) : '0;
        end else if (ccff_commit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            staging_q <= '0;
            count_q   <= '0;
            active_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            staging_q <= staging_d;
            count_q   <= count_d;
            active_q  <= active_d;
            err_q     <= err_d;
        end
    end

    assign active    = active_q;
    assign ccff_tail = staging_q[CHAIN_LEN-1];
    assign cfg_ready = full;
    assign cfg_err   = err_q;

endmodule

// File: rtl/sb_param_cfg.sv
// Switch block between right X- and bottom Y-channels; low NUM_PINS tracks per side are config muxes (SB_CFG_PARITY_EN adds frame parity).
// Routing is combinational, zero latency; new routing appears on the edge that accepts a commit.
// No backpressure: config streams in one bit per enabled cycle; bad commits set sticky cfg_err.
module sb_param_cfg
    import sb_cfg_pkg::*;
#(
    parameter int CHAN_WIDTH = 9,
    parameter int NUM_PINS   = 4
) (
    input  logic                  prog_clk,
    input  logic                  prog_reset_n,
    input  logic [CHAN_WIDTH-1:0] chanx_right_in,
    input  logic [CHAN_WIDTH-1:0] chany_bottom_in,
    input  logic [NUM_PINS-1:0]   grid_pin_in,
    input  logic                  ccff_head,
    input  logic                  ccff_en,
    input  logic                  ccff_commit,
    output logic [CHAN_WIDTH-1:0] chanx_right_out,
    output logic [CHAN_WIDTH-1:0] chany_bottom_out,
    output logic                  ccff_tail,
    output logic                  cfg_ready,
    output logic                  cfg_err
);

    localparam int CFG_BITS  = 4 * NUM_PINS;
    localparam int CHAIN_LEN = cfg_chain_len(NUM_PINS);

    logic [CFG_BITS-1:0]   active;
    logic [CHAN_WIDTH-1:0] right_dflt, bottom_dflt;

    sb_cfg_chain #(
        .DATA_W    (CFG_BITS),
        .CHAIN_LEN (CHAIN_LEN)
    ) u_chain (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .ccff_head    (ccff_head),
        .ccff_en      (ccff_en),
        .ccff_commit  (ccff_commit),
        .active       (active),
        .ccff_tail    (ccff_tail),
        .cfg_ready    (cfg_ready),
        .cfg_err      (cfg_err)
    );

    always_comb begin
        // Tracks cross reversed, except the top track which goes straight across.
        for (int j = 0; j < CHAN_WIDTH - 1; j++) begin
            bottom_dflt[j] = chanx_right_in[CHAN_WIDTH-2-j];
            right_dflt[j]  = chany_bottom_in[CHAN_WIDTH-2-j];
        end
        bottom_dflt[CHAN_WIDTH-1] = chanx_right_in[CHAN_WIDTH-1];
        right_dflt[CHAN_WIDTH-1]  = chany_bottom_in[CHAN_WIDTH-1];

        chanx_right_out  = right_dflt;
        chany_bottom_out = bottom_dflt;
        for (int i = 0; i < NUM_PINS; i++) begin
            chanx_right_out[i]  = mux_sel(mux_code_e'(active[2*i +: 2]),
                                          right_dflt[i], grid_pin_in[i]);
            chany_bottom_out[i] = mux_sel(mux_code_e'(active[2*(NUM_PINS+i) +: 2]),
                                          bottom_dflt[i], grid_pin_in[i]);
        end
    end

endmodule

// File: tb/tb_sb_param_cfg.sv
// Directed bench for sb_param_cfg with a reference routing model and an expected-value queue.
module tb_sb_param_cfg;

    localparam int CW = 9;
    localparam int NP = 4;
    localparam int CB = 16;
`ifdef SB_CFG_PARITY_EN
    localparam int N = CB + 1;
`else
    localparam int N = CB;
`endif

    logic          prog_clk = 1'b0;
    logic          prog_reset_n;
    logic [CW-1:0] chanx_right_in, chany_bottom_in;
    logic [NP-1:0] grid_pin_in;
    logic          ccff_head, ccff_en, ccff_commit;
    logic [CW-1:0] chanx_right_out, chany_bottom_out;
    logic          ccff_tail, cfg_ready, cfg_err;

    sb_param_cfg #(.CHAN_WIDTH(CW), .NUM_PINS(NP)) dut (
        .prog_clk         (prog_clk),
        .prog_reset_n     (prog_reset_n),
        .chanx_right_in   (chanx_right_in),
        .chany_bottom_in  (chany_bottom_in),
        .grid_pin_in      (grid_pin_in),
        .ccff_head        (ccff_head),
        .ccff_en          (ccff_en),
        .ccff_commit      (ccff_commit),
        .chanx_right_out  (chanx_right_out),
        .chany_bottom_out (chany_bottom_out),
        .ccff_tail        (ccff_tail),
        .cfg_ready        (cfg_ready),
        .cfg_err          (cfg_err)
    );

    always #5 prog_clk = ~prog_clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t          sb_q[$];
    int           errors = 0;
    int           checks = 0;
    logic [N-1:0] stg_m;
    logic [CB-1:0] active_m;

    function automatic logic [31:0] model_route(input logic [CB-1:0] act, input logic [CW-1:0] xi,
                                                input logic [CW-1:0] yi, input logic [NP-1:0] p);
        logic [CW-1:0] r, b;
        logic [1:0]    cr, cb;
        for (int j = 0; j < CW - 1; j++) begin
            b[j] = xi[CW-2-j];
            r[j] = yi[CW-2-j];
        end
        b[CW-1] = xi[CW-1];
        r[CW-1] = yi[CW-1];
        for (int i = 0; i < NP; i++) begin
            cr = act[2*i +: 2];
            cb = act[2*(NP+i) +: 2];
            if (cr == 2'b01) r[i] = p[i];
            else if (cr == 2'b10) r[i] = 1'b0;
            if (cb == 2'b01) b[i] = p[i];
            else if (cb == 2'b10) b[i] = 1'b0;
        end
        return {14'b0, r, b};
    endfunction

    function automatic logic [CB-1:0] data_of(input logic [N-1:0] s);
`ifdef SB_CFG_PARITY_EN
        return s[CB:1];
`else
        return s[CB-1:0];
`endif
    endfunction

    function automatic logic [N-1:0] frame_of(input logic [CB-1:0] d);
`ifdef SB_CFG_PARITY_EN
        return {d, ^d};
`else
        return d;
`endif
    endfunction

    task automatic push(input string tag, input logic [31:0] e);
        sb_q.push_back('{tag, e});
    endtask

    task automatic pop_check(input logic [31:0] obs);
        sb_t s;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: observed %h with no expected value queued", obs);
        end else begin
            s = sb_q.pop_front();
            assert (obs === s.exp)
            else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", s.tag, obs, s.exp);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
        push(tag, e);
        pop_check(obs);
    endtask

    task automatic route_chk(input string tag, input logic [CW-1:0] xi, input logic [CW-1:0] yi,
                             input logic [NP-1:0] p);
        chanx_right_in  = xi;
        chany_bottom_in = yi;
        grid_pin_in     = p;
        push(tag, model_route(active_m, xi, yi, p));
        #1;
        pop_check({14'b0, chanx_right_out, chany_bottom_out});
    endtask

    task automatic rand_route(input string tag);
        route_chk(tag, CW'($urandom), CW'($urandom), NP'($urandom));
    endtask

    task automatic shift_bit(input logic b);
        ccff_en   = 1'b1;
        ccff_head = b;
        @(posedge prog_clk);
        stg_m = {stg_m[N-2:0], b};
        #1;
        ccff_en = 1'b0;
    endtask

    task automatic shift_range(input logic [N-1:0] v, input int hi, input int lo);
        for (int k = hi; k >= lo; k--) shift_bit(v[k]);
    endtask

    task automatic commit_cycle(input logic en, input logic b, input logic acc);
        ccff_commit = 1'b1;
        ccff_en     = en;
        ccff_head   = b;
        @(posedge prog_clk);
        if (acc) active_m = data_of(stg_m);
        if (en) stg_m = {stg_m[N-2:0], b};
        #1;
        ccff_commit = 1'b0;
        ccff_en     = 1'b0;
    endtask

    // Reset is held with shift and commit both requested to exercise reset priority.
    task automatic do_reset(input int cycles);
        prog_reset_n = 1'b0;
        ccff_en      = 1'b1;
        ccff_commit  = 1'b1;
        ccff_head    = 1'b1;
        repeat (cycles) @(posedge prog_clk);
        #1;
        stg_m    = '0;
        active_m = '0;
    endtask

    task automatic release_reset();
        prog_reset_n = 1'b1;
        ccff_en      = 1'b0;
        ccff_commit  = 1'b0;
        ccff_head    = 1'b0;
    endtask

    initial begin
        logic [N-1:0] f;
        chanx_right_in  = '0;
        chany_bottom_in = '0;
        grid_pin_in     = '0;
        stg_m           = '0;
        active_m        = '0;

        // Reset state and pass-through routing
        do_reset(2);
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        chk("rst_err",   32'(cfg_err),   32'd0);
        chk("rst_tail",  32'(ccff_tail), 32'd0);
        release_reset();
        route_chk("rst_pass", 9'h1A5, 9'h0F3, 4'hA);
        chk("rst_bot_1a5", 32'(chany_bottom_out), 32'h1A5);

        // Program mux 0 to grid pin 0
        f = frame_of(16'h0001);
        shift_range(f, N - 1, 0);
        chk("frame_ready", 32'(cfg_ready), 32'd1);
        chk("frame_tail",  32'(ccff_tail), 32'(stg_m[N-1]));
        rand_route("pre_commit_hold");
        commit_cycle(1'b0, 1'b0, 1'b1);
        chk("commit_ready", 32'(cfg_ready), 32'd0);
        chk("commit_err",   32'(cfg_err),   32'd0);
        route_chk("pin0_lo", 9'h0C3, 9'h15A, 4'b1110);
        route_chk("pin0_hi", 9'h0C3, 9'h15A, 4'b0001);

        // Short frame: commit one bit early is rejected
        f = frame_of(16'hAAAA);
        shift_range(f, N - 1, 1);
        chk("short_ready", 32'(cfg_ready), 32'd0);
        commit_cycle(1'b0, 1'b0, 1'b0);
        chk("short_err", 32'(cfg_err), 32'd1);
        rand_route("short_keep");
        shift_range(f, 0, 0);
        chk("short_last_ready", 32'(cfg_ready), 32'd1);

        // Shift and commit together
        commit_cycle(1'b1, 1'b1, 1'b1);
        chk("sim_ready", 32'(cfg_ready), 32'd0);
        chk("sim_err_sticky", 32'(cfg_err), 32'd1);
        rand_route("sim_route");
        for (int k = 0; k < N - 2; k++) shift_bit(1'($urandom));
        chk("sim_cnt_nm1", 32'(cfg_ready), 32'd0);
        shift_bit(1'b0);
        chk("sim_cnt_n", 32'(cfg_ready), 32'd1);

        // Reset mid-frame discards partial bits
        do_reset(2);
        release_reset();
        for (int k = 0; k < 10; k++) shift_bit(1'($urandom));
        do_reset(1);
        release_reset();
        chk("midrst_ready", 32'(cfg_ready), 32'd0);
        chk("midrst_err",   32'(cfg_err),   32'd0);
        chk("midrst_tail",  32'(ccff_tail), 32'd0);
        rand_route("midrst_active0");
        f = frame_of(16'h6C1D);
        shift_range(f, N - 1, 1);
        chk("midrst_nm1", 32'(cfg_ready), 32'd0);
        shift_range(f, 0, 0);
        commit_cycle(1'b0, 1'b0, 1'b1);
        chk("midrst_commit_err", 32'(cfg_err), 32'd0);
        for (int k = 0; k < 3; k++) rand_route("midrst_route");

`ifdef SB_CFG_PARITY_EN
        // Wrong parity rejected, correct parity accepted
        f = {16'h0055, ~(^16'h0055)};
        shift_range(f, N - 1, 0);
        chk("par_bad_ready", 32'(cfg_ready), 32'd1);
        commit_cycle(1'b0, 1'b0, 1'b0);
        chk("par_bad_err", 32'(cfg_err), 32'd1);
        rand_route("par_bad_keep");
        f = frame_of(16'h0055);
        shift_range(f, N - 1, 0);
        commit_cycle(1'b0, 1'b0, 1'b1);
        chk("par_good_ready", 32'(cfg_ready), 32'd0);
        rand_route("par_good_route");
`endif

        // Over-shift: count saturates, oldest bits spill out
        for (int k = 0; k < 3; k++) shift_bit(1'b1);
        f = frame_of(16'h5A3C);
        shift_range(f, N - 1, 0);
        chk("over_ready", 32'(cfg_ready), 32'd1);
        chk("over_tail",  32'(ccff_tail), 32'(stg_m[N-1]));
        commit_cycle(1'b0, 1'b0, 1'b1);
        chk("over_commit_ready", 32'(cfg_ready), 32'd0);
        rand_route("over_route");

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
